// File: rtl/riscq_pkg.sv
// Shared loader definitions: FSM state encoding and data RAM geometry.
package riscq_pkg;

    localparam int RAM_ADDR_W = 12;
    localparam int RAM_WORDS  = 4096;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/data_ram_loader_if.sv
// Byte stream from the host link plus the data RAM init write port.
interface data_ram_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              init_we;
    logic [ADDR_W-1:0] init_waddr;
    logic [31:0]       init_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, init_we, init_waddr, init_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, init_we, init_waddr, init_wdata
    );
endinterface

// File: rtl/loader_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word-valid pulses the cycle after the 4th byte.
module loader_word_packer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_last,
    output logic        o_word_valid,
    output logic [31:0] o_word
);
    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;

    assign o_word_last = i_byte_en && (byte_cnt == 2'd3);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            byte_cnt     <= '0;
            shift_q      <= '0;
            o_word_valid <= 1'b0;
            o_word       <= '0;
        end else begin
            o_word_valid <= o_word_last;
            if (i_clr) begin
                byte_cnt <= '0;
                shift_q  <= '0;
            end else if (i_byte_en) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift_q  <= {i_byte, shift_q[23:8]};
                // o_word only moves on completion, so it holds until the next write
                if (byte_cnt == 2'd3)
                    o_word <= {i_byte, shift_q};
            end
        end
    end
endmodule

// File: rtl/data_ram_loader.sv
// Boot-image loader: header count, packed data words to RAM init port, then init-done.
// Optional trailing XOR checksum byte enabled by DATA_RAM_LOADER_CHKSUM_EN.
module data_ram_loader
    import riscq_pkg::*;
#(
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int MAX_WORDS = RAM_WORDS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load_start,
    data_ram_loader_if.slave    bus,
    output logic                o_init_done,
    output logic                o_init_err,
    output logic                o_busy
);
    loader_state_t     state;
    logic [7:0]        cnt_lo;
    logic [15:0]       cnt_words;
    logic [15:0]       hdr_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] waddr_q;
    logic              accept;
    logic              byte_en;
    logic              start_ok;
    logic              word_last;
    logic              word_valid;
    logic              last_word;
    logic [31:0]       word;
`ifdef DATA_RAM_LOADER_CHKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign bus.rx_ready   = state inside {ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM};
    assign o_busy         = bus.rx_ready;
    assign accept         = bus.rx_valid && bus.rx_ready;
    assign byte_en        = accept && (state == ST_DATA);
    assign start_ok       = i_load_start && (state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign hdr_cnt        = {bus.rx_data, cnt_lo};
    assign last_word      = 32'(word_idx) == 32'(cnt_words) - 32'd1;
    assign bus.init_we    = word_valid;
    assign bus.init_waddr = waddr_q;
    assign bus.init_wdata = word;

    loader_word_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr        (start_ok),
        .i_byte_en    (byte_en),
        .i_byte       (bus.rx_data),
        .o_word_last  (word_last),
        .o_word_valid (word_valid),
        .o_word       (word)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            cnt_lo      <= '0;
            cnt_words   <= '0;
            word_idx    <= '0;
            waddr_q     <= '0;
            o_init_done <= 1'b0;
            o_init_err  <= 1'b0;
`ifdef DATA_RAM_LOADER_CHKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
`ifdef DATA_RAM_LOADER_CHKSUM_EN
            if (accept && state != ST_CSUM)
                csum_q <= csum_q ^ bus.rx_data;
`endif
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_ok) begin
                        state       <= ST_HDR0;
                        word_idx    <= '0;
                        o_init_done <= 1'b0;
                        o_init_err  <= 1'b0;
`ifdef DATA_RAM_LOADER_CHKSUM_EN
                        csum_q      <= '0;
`endif
                    end else if (state == ST_DONE) begin
                        // entered the cycle of the last write strobe, so done lands one cycle later
                        o_init_done <= 1'b1;
                    end
                end
                ST_HDR0: begin
                    if (accept) begin
                        cnt_lo <= bus.rx_data;
                        state  <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (accept) begin
                        cnt_words <= hdr_cnt;
                        if (32'(hdr_cnt) > 32'(MAX_WORDS)) begin
                            state      <= ST_ERR;
                            o_init_err <= 1'b1;
                        end else if (hdr_cnt == 16'd0) begin
`ifdef DATA_RAM_LOADER_CHKSUM_EN
                            state <= ST_CSUM;
`else
                            state <= ST_DONE;
`endif
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_last) begin
                        waddr_q  <= word_idx;
                        word_idx <= word_idx + ADDR_W'(1);
                        if (last_word) begin
`ifdef DATA_RAM_LOADER_CHKSUM_EN
                            state <= ST_CSUM;
`else
                            state <= ST_DONE;
`endif
                        end
                    end
                end
`ifdef DATA_RAM_LOADER_CHKSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        if (bus.rx_data == csum_q) begin
                            state       <= ST_DONE;
                            o_init_done <= 1'b1;
                        end else begin
                            state      <= ST_ERR;
                            o_init_err <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_ram_loader.sv
// Scoreboarded bench for data_ram_loader; follows DATA_RAM_LOADER_CHKSUM_EN if defined.
module tb_data_ram_loader;
    localparam int ADDR_W = 12;
    localparam int MAXW   = 4096;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic done, err, busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         exp_q[$];
    logic [31:0] words[$];

    data_ram_loader_if #(.ADDR_W(ADDR_W)) bus ();

    data_ram_loader dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load_start (start),
        .bus          (bus),
        .o_init_done  (done),
        .o_init_err   (err),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // write monitor: every strobe must match the head of the expected queue
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.init_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(bus.init_waddr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("waddr", 32'(bus.init_waddr), 32'(e.a));
                    check("wdata", bus.init_wdata, e.d);
                end
                check("done_with_we", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int n;
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(3, 1)) @(negedge clk);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(bus.rx_ready), 32'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", 32'(bus.rx_ready), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
        check("start_err_clr", 32'(err), 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4 && done !== 1'b1; i++) @(negedge clk);
        check("done_level", 32'(done), 32'd1);
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom());
    endtask

    // reference: N little-endian words, XOR of all header/data bytes as checksum
    task automatic load_frame(input int n, input int gap, input bit bad);
        logic [7:0]  cs;
        logic [31:0] w;
        wr_t         e;
        cs = 8'h00;
        if (n <= MAXW) begin
            for (int i = 0; i < n; i++) begin
                e.a = ADDR_W'(i);
                e.d = words[i];
                exp_q.push_back(e);
            end
        end
        send_byte(8'(n), gap);
        cs = cs ^ 8'(n);
        send_byte(8'(n >> 8), gap);
        cs = cs ^ 8'(n >> 8);
        if (n > MAXW) begin
            check("oversize_err", 32'(err), 32'd1);
            check("oversize_ready", 32'(bus.rx_ready), 32'd0);
            check("oversize_busy", 32'(busy), 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], gap);
                cs = cs ^ w[8*k +: 8];
            end
            check("we_latency", 32'(bus.init_we), 32'd1);
        end
`ifdef DATA_RAM_LOADER_CHKSUM_EN
        send_byte(cs ^ {7'd0, bad}, gap);
        check("csum_done", 32'(done), bad ? 32'd0 : 32'd1);
        check("csum_err", 32'(err), bad ? 32'd1 : 32'd0);
        check("end_ready", 32'(bus.rx_ready), 32'd0);
`else
        if (n > 0) begin
            check("done_not_with_we", 32'(done), 32'd0);
            @(negedge clk);
            check("done_after_we", 32'(done), 32'd1);
        end else begin
            wait_done();
        end
        check("end_err", 32'(err), 32'd0);
        check("bad_unused", 32'(bad), 32'd0);
`endif
        check("writes_missing", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.rx_ready), 32'd0);
        check("rst_we", 32'(bus.init_we), 32'd0);
        check("rst_waddr", 32'(bus.init_waddr), 32'd0);
        check("rst_wdata", bus.init_wdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.rx_ready), 32'd0);

        words.delete();
        words.push_back(32'h1234_5678);
        words.push_back(32'hDEAD_BEEF);
        pulse_start();
        load_frame(2, 0, 1'b0);

`ifdef DATA_RAM_LOADER_CHKSUM_EN
        pulse_start();
        load_frame(2, 0, 1'b1);
        repeat (2) @(negedge clk);
        check("badcs_done_stays", 32'(done), 32'd0);
`endif

        words.delete();
        pulse_start();
        load_frame(32'h1001, 0, 1'b0);
        rand_words(1);
        pulse_start();
        load_frame(1, 0, 1'b0);

        // bytes offered while DONE must be ignored
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("done_ready_low", 32'(bus.rx_ready), 32'd0);
        check("done_holds", 32'(done), 32'd1);
        bus.rx_valid = 1'b0;

        rand_words(16);
        pulse_start();
        load_frame(16, 40, 1'b0);

        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'(bus.rx_ready), 32'd0);
        check("arst_we", 32'(bus.init_we), 32'd0);
        check("arst_waddr", 32'(bus.init_waddr), 32'd0);
        check("arst_wdata", bus.init_wdata, 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rand_words(3);
        pulse_start();
        load_frame(3, 0, 1'b0);

        // zero length, with a start pulse landing mid-header
        pulse_start();
        send_byte(8'h00, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_ignored", 32'(busy), 32'd1);
        words.delete();
        send_byte(8'h00, 0);
`ifdef DATA_RAM_LOADER_CHKSUM_EN
        send_byte(8'h00, 0);
        check("zero_done", 32'(done), 32'd1);
`else
        wait_done();
`endif
        check("zero_no_writes", 32'(exp_q.size()), 32'd0);

        for (int f = 0; f < 4; f++) begin
            rand_words($urandom_range(8, 1));
            pulse_start();
            load_frame(words.size(), (f % 2) * 30, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
